connect4_board_drawer: RTL and testbench
========================================

// Module: connect4_board_drawer
// PURPOSE
//  Read side of the Connect 4 board store: scans all 42 cells through a registered read port
//  and streams one pixel per cycle to the VGA adapter (x, y, colour, plot), 160x120, 3-bit RGB.
//  Sits between the game-logic board store and vga_adapter; game logic pulses refresh after each move.
// PARAMETERS
//  CELL_SIZE  16   pixel edge of one cell square (power of 2, 4..16)
//  ORIGIN_X   24   x of left edge of column 0
//  ORIGIN_Y   8    y of cursor band; board row 0 starts at ORIGIN_Y+CELL_SIZE
// PORTS
//  CLOCK_50   in   1  system clock
//  Resetn     in   1  reset, asynchronous, active-low
//  refresh    in   1  request full redraw (level sampled each clock)
//  win        in   1  game won; sampled at frame start, selects grid colour
//  cur_col    in   3  cursor column 0..6; sampled at frame start
//  p2_turn    in   1  1 = player 2 to move; sampled at frame start
//  cell_addr  out  6  board index row*7+col (row 0 = top)
//  cell_data  in   2  cell code, valid one cycle after cell_addr: 00 empty, 01 P1, 10 P2, 11 invalid
//  vga_x      out  8  pixel x
//  vga_y      out  7  pixel y
//  vga_colour out  3  pixel colour RGB
//  vga_plot   out  1  write strobe, one pixel per asserted cycle
//  busy       out  1  frame in progress
//  done       out  1  one-cycle pulse after last pixel of a frame
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; pending flag 0; cell/pixel counters 0. Reset mid-frame aborts
//    at once, vga_plot drops asynchronously, no done pulse.
//  - IDLE: refresh=1 -> latch win/cur_col/p2_turn, busy=1 next cycle, go FETCH (or CURSOR if enabled).
//  - FETCH: drive cell_addr = row*7+col -> WAIT. WAIT: register cell_data into cell_q -> DRAW.
//  - DRAW: dx,dy scan 0..CELL_SIZE-1, dx fastest; one pixel/cycle, vga_plot=1;
//    x = ORIGIN_X+col*CELL_SIZE+dx, y = ORIGIN_Y+(row+1)*CELL_SIZE+dy.
//    Colour: dx==0 or dy==0 -> grid (win ? 3'b010 : 3'b001); else by cell_q: 00->000, 01->100,
//    10->110, 11->101.
//  - After dx=dy=CELL_SIZE-1: col++; col 6 wraps to 0 with row++; after row 5 col 6 -> DONE.
//  - DONE: done=1 for one cycle, busy=0 the following cycle -> IDLE.
//  - Per cell: 2 + CELL_SIZE^2 cycles; default frame 42*258 = 10836 cycles (+ cursor band).
//  - refresh held/asserted while busy: set pending; on DONE with pending, clear it and restart
//    directly (busy stays 1, done still pulses). At most one pending frame is queued.
//  - Inputs sampled only at frame start; mid-frame changes affect the next frame only.
//  - Arithmetic in 8-bit unsigned; default layout max x=135, max y=119, never exceeds 159/119.
//  - vga_plot=0 in IDLE/FETCH/WAIT/DONE; vga_x/vga_y/vga_colour hold last value when plot=0.
// CONFIGURATION
//  CONNECT4_CURSOR_EN defined: CURSOR state precedes first FETCH; draws 7 squares of the band at
//    y=ORIGIN_Y..+CELL_SIZE-1, square cur_col coloured current player (p2_turn ? 110 : 100),
//    others 000; 7*CELL_SIZE^2 extra cycles, no cell reads.
//  Not defined: no CURSOR state, band never written; cur_col and p2_turn ignored.
// STRUCTURE
//  connect4_pkg: BOARD_ROWS=6, BOARD_COLS=7, cell codes EMPTY/P1/P2, colour constants, state enum.
//  Sub-module c4_cell_raster: dx/dy counter with clear, enable and last-pixel flag; reused
//  by DRAW and CURSOR. FSM, row/col counters and address/pixel math in top.
// TESTING
//  1 Reset, empty board model, refresh 1 cycle -> 10836 plots, first (24,24) colour 001,
//    (25,25) 000, done once, busy high exactly 10837 cycles.
//  2 Board index 38 = P1, 39 = P2 -> pixel (73,113) = 100, (89,113) = 110, cell_addr 38 then 39.
//  3 win=1 at refresh -> every dx==0/dy==0 pixel 010; win dropped mid-frame -> colour unchanged.
//  4 refresh re-pulsed at cycle 5000 -> done pulses twice, busy never drops between frames,
//    a third pulse during frame 1 still yields only 2 frames.
//  5 Resetn low at cycle 3000 -> vga_plot=0, busy=0 immediately, no done; next refresh full frame.
//  6 CONNECT4_CURSOR_EN, cur_col=6, p2_turn=1 -> (120..135, 8..23) = 110, rest of band 000,
//    frame 10836+1792 cycles.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared constants, cell codes, colours and FSM states for the Connect 4 board drawer.
package connect4_pkg;

    localparam int BOARD_ROWS = 6;
    localparam int BOARD_COLS = 7;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_P1    = 2'b01,
        CELL_P2    = 2'b10,
        CELL_BAD   = 2'b11
    } cell_t;

    localparam logic [2:0] COL_EMPTY    = 3'b000;
    localparam logic [2:0] COL_P1       = 3'b100;
    localparam logic [2:0] COL_P2       = 3'b110;
    localparam logic [2:0] COL_BAD      = 3'b101;
    localparam logic [2:0] COL_GRID     = 3'b001;
    localparam logic [2:0] COL_GRID_WIN = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CURSOR,
        S_FETCH,
        S_WAIT,
        S_DRAW,
        S_DONE
    } state_t;

    function automatic logic [2:0] cell_colour(input logic [1:0] code);
        logic [2:0] c;
        case (cell_t'(code))
            CELL_EMPTY: c = COL_EMPTY;
            CELL_P1:    c = COL_P1;
            CELL_P2:    c = COL_P2;
            default:    c = COL_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/c4_cell_raster.sv
// dx/dy scan counter for one CELL_SIZE x CELL_SIZE square, dx fastest; wraps to 0 after the last pixel.
module c4_cell_raster #(
    parameter int CELL_SIZE = 16,
    localparam int W = $clog2(CELL_SIZE)
) (
    input  logic         CLOCK_50,
    input  logic         Resetn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] dx,
    output logic [W-1:0] dy,
    output logic         last
);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            dx <= '0;
            dy <= '0;
        end else if (clr) begin
            dx <= '0;
            dy <= '0;
        end else if (en) begin
            dx <= dx + 1'b1;
            if (dx == '1)
                dy <= dy + 1'b1;
        end
    end

    assign last = (dx == '1) && (dy == '1);

endmodule

// File: rtl/connect4_board_drawer.sv
// Scans the 42 board cells through a registered read port and streams pixels to the VGA adapter.
// Optional cursor band before the board: define CONNECT4_CURSOR_EN.
module connect4_board_drawer
    import connect4_pkg::*;
#(
    parameter int CELL_SIZE = 16,
    parameter int ORIGIN_X  = 24,
    parameter int ORIGIN_Y  = 8
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       refresh,
    input  logic       win,
    input  logic [2:0] cur_col,
    input  logic       p2_turn,
    output logic [5:0] cell_addr,
    input  logic [1:0] cell_data,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam int RW = $clog2(CELL_SIZE);
    localparam logic [2:0] LAST_ROW = 3'(BOARD_ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(BOARD_COLS - 1);
`ifdef CONNECT4_CURSOR_EN
    localparam state_t FIRST_ST = S_CURSOR;
`else
    localparam state_t FIRST_ST = S_FETCH;
`endif

    state_t          state, state_nxt;
    logic            load;
    logic [2:0]      row, col;
    logic [1:0]      cell_q;
    logic            win_q, pending;
    logic [RW-1:0]   dx, dy;
    logic            last_px, drawing;
    logic [7:0]      px_x, px_y;
    logic [2:0]      px_c;
    logic [7:0]      x_hold;
    logic [6:0]      y_hold;
    logic [2:0]      c_hold;
    logic            unused_y_msb;

`ifdef CONNECT4_CURSOR_EN
    logic [2:0] cur_col_q;
    logic       p2_q;
`else
    logic       unused_cursor;
    assign unused_cursor = ^{cur_col, p2_turn};
`endif

    assign drawing = (state == S_DRAW) || (state == S_CURSOR);

    c4_cell_raster #(.CELL_SIZE(CELL_SIZE)) u_raster (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .clr      (!drawing),
        .en       (drawing),
        .dx       (dx),
        .dy       (dy),
        .last     (last_px)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_IDLE:   if (refresh) begin
                          load      = 1'b1;
                          state_nxt = FIRST_ST;
                      end
            S_CURSOR: if (last_px && col == LAST_COL) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_WAIT;
            S_WAIT:   state_nxt = S_DRAW;
            S_DRAW:   if (last_px)
                          state_nxt = (row == LAST_ROW && col == LAST_COL) ? S_DONE : S_FETCH;
            S_DONE:   if (pending || refresh) begin
                          // queued request restarts straight away, busy never drops
                          load      = 1'b1;
                          state_nxt = FIRST_ST;
                      end else begin
                          state_nxt = S_IDLE;
                      end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            busy    <= 1'b0;
            pending <= 1'b0;
            win_q   <= 1'b0;
            row     <= '0;
            col     <= '0;
            cell_q  <= '0;
            x_hold  <= '0;
            y_hold  <= '0;
            c_hold  <= '0;
        end else begin
            if (load)                 busy <= 1'b1;
            else if (state == S_DONE) busy <= 1'b0;

            if (state == S_DONE)      pending <= 1'b0;
            else if (busy && refresh) pending <= 1'b1;

            if (load) begin
                win_q <= win;
                row   <= '0;
                col   <= '0;
            end else if (state == S_CURSOR && last_px) begin
                col <= (col == LAST_COL) ? 3'd0 : col + 3'd1;
            end else if (state == S_DRAW && last_px) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? 3'd0 : row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end

            if (state == S_WAIT) cell_q <= cell_data;

            if (drawing) begin
                x_hold <= px_x;
                y_hold <= px_y[6:0];
                c_hold <= px_c;
            end
        end
    end

`ifdef CONNECT4_CURSOR_EN
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            cur_col_q <= '0;
            p2_q      <= 1'b0;
        end else if (load) begin
            cur_col_q <= cur_col;
            p2_q      <= p2_turn;
        end
    end
`endif

    always_comb begin
        px_x = 8'(ORIGIN_X) + 8'(col) * 8'(CELL_SIZE) + 8'(dx);
        px_y = 8'(ORIGIN_Y) + (8'(row) + 8'd1) * 8'(CELL_SIZE) + 8'(dy);
        if (dx == '0 || dy == '0) px_c = win_q ? COL_GRID_WIN : COL_GRID;
        else                      px_c = cell_colour(cell_q);
`ifdef CONNECT4_CURSOR_EN
        if (state == S_CURSOR) begin
            px_y = 8'(ORIGIN_Y) + 8'(dy);
            px_c = (col == cur_col_q) ? (p2_q ? COL_P2 : COL_P1) : COL_EMPTY;
        end
`endif
    end

    assign unused_y_msb = px_y[7];
    assign cell_addr    = 6'(row) * 6'(BOARD_COLS) + 6'(col);
    assign vga_plot     = drawing;
    assign vga_x        = drawing ? px_x      : x_hold;
    assign vga_y        = drawing ? px_y[6:0] : y_hold;
    assign vga_colour   = drawing ? px_c      : c_hold;
    assign done         = (state == S_DONE);

endmodule

// File: tb/tb_connect4_board_drawer.sv
// Randomized boards checked against a per-frame pixel list built directly from the drawing rules.
module tb_connect4_board_drawer;

    localparam int CS = 16;
    localparam int OX = 24;
    localparam int OY = 8;
`ifdef CONNECT4_CURSOR_EN
    localparam int CUR_CYC = 7 * CS * CS;
`else
    localparam int CUR_CYC = 0;
`endif
    localparam int FRAME_PLOTS = 42 * CS * CS + CUR_CYC;
    localparam int BUSY_CYC    = 42 * (2 + CS * CS) + CUR_CYC + 1;

    logic       CLOCK_50, Resetn, refresh, win, p2_turn;
    logic [2:0] cur_col;
    logic [5:0] cell_addr;
    logic [1:0] cell_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, done;

    connect4_board_drawer dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .refresh    (refresh),
        .win        (win),
        .cur_col    (cur_col),
        .p2_turn    (p2_turn),
        .cell_addr  (cell_addr),
        .cell_data  (cell_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic [1:0] board [0:41];
    always @(posedge CLOCK_50) cell_data <= board[cell_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // monitor state
    bit          mon_en = 1'b0;
    int          plots, busy_cyc, done_cnt, pix_mism, addr_bad, addr_n, busy_falls;
    logic        busy_prev;
    logic [5:0]  last_addr;
    logic [17:0] expq [$];
    logic [2:0]  img [0:159][0:119];

    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            if (busy) busy_cyc++;
            if (busy_prev && !busy) busy_falls++;
            busy_prev = busy;
            if (done) done_cnt++;
            if (vga_plot) begin
                plots++;
                img[vga_x][vga_y] = vga_colour;
                if (expq.size() > 0) begin
                    if (expq.pop_front() !== {vga_x, vga_y, vga_colour}) pix_mism++;
                end else begin
                    pix_mism++;
                end
            end
            if (cell_addr !== last_addr) begin
                if (cell_addr !== 6'((addr_n + 1) % 42)) addr_bad++;
                addr_n++;
                last_addr = cell_addr;
            end
        end
    end

    task automatic mon_clear();
        plots = 0; busy_cyc = 0; done_cnt = 0; pix_mism = 0;
        addr_bad = 0; addr_n = 0; busy_falls = 0; busy_prev = 1'b0;
        last_addr = 6'd0;
        expq.delete();
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                img[x][y] = 3'b111;
        mon_en = 1'b1;
    endtask

    function automatic logic [2:0] code_colour(input logic [1:0] code);
        case (code)
            2'b00:   return 3'b000;
            2'b01:   return 3'b100;
            2'b10:   return 3'b110;
            default: return 3'b101;
        endcase
    endfunction

    // expected pixel stream for one frame from the current board and sampled inputs
    task automatic push_frame(input bit w);
        int x, y;
        logic [2:0] c;
`ifdef CONNECT4_CURSOR_EN
        for (int sq = 0; sq < 7; sq++)
            for (int dy = 0; dy < CS; dy++)
                for (int dx = 0; dx < CS; dx++) begin
                    c = (sq == int'(cur_col)) ? (p2_turn ? 3'b110 : 3'b100) : 3'b000;
                    expq.push_back({8'(OX + sq * CS + dx), 7'(OY + dy), c});
                end
`endif
        for (int r = 0; r < 6; r++)
            for (int cl = 0; cl < 7; cl++)
                for (int dy = 0; dy < CS; dy++)
                    for (int dx = 0; dx < CS; dx++) begin
                        x = OX + cl * CS + dx;
                        y = OY + (r + 1) * CS + dy;
                        c = (dx == 0 || dy == 0) ? (w ? 3'b010 : 3'b001)
                                                 : code_colour(board[r * 7 + cl]);
                        expq.push_back({8'(x), 7'(y), c});
                    end
    endtask

    task automatic pulse_refresh();
        @(posedge CLOCK_50); #1 refresh = 1'b1;
        @(posedge CLOCK_50); #1 refresh = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge CLOCK_50);
            n++;
        end
        chk("done_timeout", 32'(done_cnt >= target), 32'd1);
        repeat (4) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic random_board();
        for (int i = 0; i < 42; i++) board[i] = 2'($urandom_range(0, 3));
    endtask

    initial begin
        Resetn = 1'b0; refresh = 1'b0; win = 1'b0; cur_col = 3'd0; p2_turn = 1'b0;
        for (int i = 0; i < 42; i++) board[i] = 2'b00;
        #12;
        chk("rst_plot", 32'(vga_plot), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(cell_addr), 0);
        chk("rst_xyc", 32'({vga_x, vga_y, vga_colour}), 0);
        @(posedge CLOCK_50); #1 Resetn = 1'b1;

        // empty board, single frame
        mon_clear();
        push_frame(1'b0);
        pulse_refresh();
        wait_done(1, BUSY_CYC + 50);
        chk("t1_plots", 32'(plots), 32'(FRAME_PLOTS));
        chk("t1_pix", 32'(pix_mism), 0);
        chk("t1_px24", 32'(img[24][24]), 32'd1);
        chk("t1_px25", 32'(img[25][25]), 32'd0);
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_busycyc", 32'(busy_cyc), 32'(BUSY_CYC));
        chk("t1_idle", 32'(busy), 0);

        // random board with fixed P1/P2 at 38/39
        random_board();
        board[38] = 2'b01; board[39] = 2'b10;
        cur_col = 3'd6; p2_turn = 1'b1;
        mon_clear();
        push_frame(1'b0);
        pulse_refresh();
        wait_done(1, BUSY_CYC + 50);
        chk("t2_p1", 32'(img[73][113]), 32'd4);
        chk("t2_p2", 32'(img[89][113]), 32'd6);
        chk("t2_pix", 32'(pix_mism), 0);
        chk("t2_addr_seq", 32'(addr_bad), 0);
        chk("t2_addr_n", 32'(addr_n), 32'd42);
`ifdef CONNECT4_CURSOR_EN
        chk("t2_cur_lo", 32'(img[120][8]), 32'd6);
        chk("t2_cur_hi", 32'(img[135][23]), 32'd6);
        chk("t2_cur_off", 32'(img[119][8]), 32'd0);
`endif

        // win grid, inputs changed mid-frame must not matter
        random_board();
        win = 1'b1; cur_col = 3'($urandom_range(0, 6)); p2_turn = 1'($urandom_range(0, 1));
        mon_clear();
        push_frame(1'b1);
        pulse_refresh();
        repeat (2000) @(posedge CLOCK_50);
        #1 win = 1'b0; cur_col = 3'd3; p2_turn = ~p2_turn;
        wait_done(1, BUSY_CYC + 50);
        chk("t3_grid0", 32'(img[24][24]), 32'd2);
        chk("t3_grid1", 32'(img[120][104]), 32'd2);
        chk("t3_pix", 32'(pix_mism), 0);

        // queued refreshes: two requests during frame 1 give exactly one more frame
        random_board();
        win = 1'($urandom_range(0, 1)); cur_col = 3'($urandom_range(0, 6));
        mon_clear();
        push_frame(win);
        push_frame(win);
        pulse_refresh();
        repeat (4998) @(posedge CLOCK_50);
        pulse_refresh();
        repeat (2000) @(posedge CLOCK_50);
        pulse_refresh();
        wait_done(2, 2 * BUSY_CYC + 100);
        chk("t4_done", 32'(done_cnt), 32'd2);
        chk("t4_plots", 32'(plots), 32'(2 * FRAME_PLOTS));
        chk("t4_busycyc", 32'(busy_cyc), 32'(2 * BUSY_CYC));
        chk("t4_busyfall", 32'(busy_falls), 32'd1);
        chk("t4_pix", 32'(pix_mism), 0);

        // reset mid-frame aborts at once
        random_board();
        mon_clear();
        pulse_refresh();
        repeat (3000) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("t5_plot_pre", 32'(vga_plot), 32'd1);
        #1 mon_en = 1'b0; Resetn = 1'b0;
        #1;
        chk("t5_plot_rst", 32'(vga_plot), 0);
        chk("t5_busy_rst", 32'(busy), 0);
        chk("t5_done_rst", 32'(done), 0);
        @(posedge CLOCK_50); #1 Resetn = 1'b1;
        repeat (20) @(posedge CLOCK_50);
        #1;
        chk("t5_no_done", 32'(done_cnt), 0);
        chk("t5_idle", 32'(busy), 0);
        mon_clear();
        push_frame(win);
        pulse_refresh();
        wait_done(1, BUSY_CYC + 50);
        chk("t5_plots", 32'(plots), 32'(FRAME_PLOTS));
        chk("t5_pix", 32'(pix_mism), 0);
        chk("t5_done", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
